// File: rtl/mdu_sequencer_if.sv
// Handshake/data bundle between E-stage decode and the MDU sequencer.
interface mdu_sequencer_if;
  logic        req;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_mdu_use;
  logic        busy;
  logic        stall_d;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output req, start, op, a, b, d_mdu_use, input busy, stall_d, hi, lo);
  modport slave  (input req, start, op, a, b, d_mdu_use, output busy, stall_d, hi, lo);
endinterface

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer owning architectural HI/LO.
// Optional `MDU_MADD_EN enables op 7 (madd: {hi,lo} += signed a*b).
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic          clk,
  input logic          reset,
  mdu_sequencer_if.slave mdu
);
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd7;
`endif
  localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

  state_t      state, state_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic [63:0] pend, pend_nxt;
  logic [31:0] hi_q, hi_nxt, lo_q, lo_nxt;

  logic [63:0] smul, umul, div_res;
  logic        sdiv;
  logic [31:0] dvd, dvs, uq, ur, q, r;

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign smul = {{32{mdu.a[31]}}, mdu.a} * {{32{mdu.b[31]}}, mdu.b};
  assign umul = {32'd0, mdu.a} * {32'd0, mdu.b};

  // One unsigned divider serves both div and divu; signed div works on
  // magnitudes, which also yields 0x8000_0000 rem 0 for the overflow case.
  assign sdiv    = (mdu.op == OP_DIV);
  assign dvd     = (sdiv && mdu.a[31]) ? -mdu.a : mdu.a;
  assign dvs     = (sdiv && mdu.b[31]) ? -mdu.b : mdu.b;
  assign uq      = dvd / dvs;
  assign ur      = dvd % dvs;
  assign q       = (sdiv && (mdu.a[31] ^ mdu.b[31])) ? -uq : uq;
  assign r       = (sdiv && mdu.a[31]) ? -ur : ur;
  assign div_res = (mdu.b == 32'd0) ? {mdu.a, 32'hFFFF_FFFF} : {r, q};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    hi_nxt    = hi_q;
    lo_nxt    = lo_q;
    case (state)
      IDLE: begin
        if (mdu.start && !mdu.req) begin
          case (mdu.op)
            OP_MULT:  begin pend_nxt = smul;    cnt_nxt = MULT_N; state_nxt = RUN; end
            OP_MULTU: begin pend_nxt = umul;    cnt_nxt = MULT_N; state_nxt = RUN; end
            OP_DIV,
            OP_DIVU:  begin pend_nxt = div_res; cnt_nxt = DIV_N;  state_nxt = RUN; end
            OP_MTHI:  hi_nxt = mdu.a;
            OP_MTLO:  lo_nxt = mdu.a;
`ifdef MDU_MADD_EN
            OP_MADD:  begin pend_nxt = {hi_q, lo_q} + smul; cnt_nxt = MULT_N; state_nxt = RUN; end
`endif
            default: ;
          endcase
        end
      end
      RUN: begin
        // Flush wins over the commit edge so HI/LO stay precise.
        if (mdu.req) begin
          state_nxt = IDLE;
          cnt_nxt   = 5'd0;
          pend_nxt  = 64'd0;
        end else if (cnt == 5'd1) begin
          state_nxt = IDLE;
          cnt_nxt   = 5'd0;
          hi_nxt    = pend[63:32];
          lo_nxt    = pend[31:0];
        end else begin
          cnt_nxt = cnt - 5'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 5'd0;
      pend  <= 64'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pend  <= pend_nxt;
      hi_q  <= hi_nxt;
      lo_q  <= lo_nxt;
    end
  end

  assign mdu.busy    = (state == RUN);
  assign mdu.stall_d = mdu.d_mdu_use && (mdu.start || mdu.busy);
  assign mdu.hi      = hi_q;
  assign mdu.lo      = lo_q;
endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer (MULT_CYCLES=5, DIV_CYCLES=10).
module tb_mdu_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mdu_sequencer_if bus();
  mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .mdu(bus));

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Pulse start for one edge, then scramble operands to prove they were latched.
  task automatic issue(input logic [2:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                       input logic req_v);
    bus.start = 1'b1; bus.op = op_v; bus.a = a_v; bus.b = b_v; bus.req = req_v;
    step();
    bus.start = 1'b0; bus.op = 3'd0; bus.req = 1'b0;
    bus.a = 32'hDEAD_BEEF; bus.b = 32'h0BAD_F00D;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'h1111_1111;
    repeat (3) step();
    bus.start = 1'b0; bus.op = 3'd0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", bus.hi); end
    n_checks++; if (bus.lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", bus.lo); end
    n_checks++; if (bus.stall_d !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", bus.stall_d); end
    reset = 1'b0;
    step();
    n_checks++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL post_reset_hi got %h want 0", bus.hi); end
  endtask

  task automatic test_mult();
    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy cyc %0d got %b want 1", i + 1, bus.busy); end
      step();
    end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mult_done got %b want 0", bus.busy); end
    n_checks++; if (bus.hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got %h want ffffffff", bus.hi); end
    n_checks++; if (bus.lo !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL mult_lo got %h want fffffffa", bus.lo); end
    issue(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL multu_busy cyc %0d got %b want 1", i + 1, bus.busy); end
      step();
    end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL multu_done got %b want 0", bus.busy); end
    n_checks++; if (bus.hi !== 32'h0000_0002) begin n_fail++; $display("FAIL multu_hi got %h want 00000002", bus.hi); end
    n_checks++; if (bus.lo !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL multu_lo got %h want fffffffa", bus.lo); end
  endtask

  task automatic test_div();
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL div_busy cyc %0d got %b want 1", i + 1, bus.busy); end
      step();
    end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL div_done got %b want 0", bus.busy); end
    n_checks++; if (bus.lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo got %h want fffffffd", bus.lo); end
    n_checks++; if (bus.hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi got %h want ffffffff", bus.hi); end
    issue(3'd4, 32'd7, 32'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL divu_busy cyc %0d got %b want 1", i + 1, bus.busy); end
      step();
    end
    n_checks++; if (bus.lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu0_lo got %h want ffffffff", bus.lo); end
    n_checks++; if (bus.hi !== 32'd7) begin n_fail++; $display("FAIL divu0_hi got %h want 00000007", bus.hi); end
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    repeat (10) step();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL divovf_done got %b want 0", bus.busy); end
    n_checks++; if (bus.lo !== 32'h8000_0000) begin n_fail++; $display("FAIL divovf_lo got %h want 80000000", bus.lo); end
    n_checks++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL divovf_hi got %h want 0", bus.hi); end
  endtask

  task automatic test_abort();
    issue(3'd5, 32'h1234, 32'd0, 1'b0);
    n_checks++; if (bus.hi !== 32'h1234) begin n_fail++; $display("FAIL mthi got %h want 00001234", bus.hi); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy got %b want 0", bus.busy); end
    issue(3'd6, 32'h5678, 32'd0, 1'b0);
    n_checks++; if (bus.lo !== 32'h5678) begin n_fail++; $display("FAIL mtlo got %h want 00005678", bus.lo); end
    issue(3'd3, 32'd100, 32'd7, 1'b0);
    repeat (3) step();
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL abort_prebusy got %b want 1", bus.busy); end
    bus.req = 1'b1;
    step();
    bus.req = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", bus.busy); end
    repeat (12) step();
    n_checks++; if (bus.hi !== 32'h1234) begin n_fail++; $display("FAIL abort_hi got %h want 00001234", bus.hi); end
    n_checks++; if (bus.lo !== 32'h5678) begin n_fail++; $display("FAIL abort_lo got %h want 00005678", bus.lo); end
  endtask

  task automatic test_req_commit();
    issue(3'd1, 32'd2, 32'd3, 1'b0);
    repeat (4) step();
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL lastcyc_busy got %b want 1", bus.busy); end
    bus.req = 1'b1;
    step();
    bus.req = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reqcommit_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.lo !== 32'h5678) begin n_fail++; $display("FAIL reqcommit_lo got %h want 00005678", bus.lo); end
    n_checks++; if (bus.hi !== 32'h1234) begin n_fail++; $display("FAIL reqcommit_hi got %h want 00001234", bus.hi); end
    issue(3'd1, 32'd2, 32'd3, 1'b1);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL startreq_busy got %b want 0", bus.busy); end
    repeat (6) step();
    n_checks++; if (bus.lo !== 32'h5678) begin n_fail++; $display("FAIL startreq_lo got %h want 00005678", bus.lo); end
    issue(3'd5, 32'h9999, 32'd0, 1'b1);
    n_checks++; if (bus.hi !== 32'h1234) begin n_fail++; $display("FAIL mthireq_hi got %h want 00001234", bus.hi); end
  endtask

  task automatic test_stall();
    bus.d_mdu_use = 1'b1;
    bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'd100; bus.b = 32'd7;
    #1;
    n_checks++; if (bus.stall_d !== 1'b1) begin n_fail++; $display("FAIL stall_start got %b want 1", bus.stall_d); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL stall_prebusy got %b want 0", bus.busy); end
    step();
    bus.start = 1'b0; bus.op = 3'd0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'd5; bus.b = 32'd5; #1; end
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy cyc %0d got %b want 1", i + 1, bus.busy); end
      n_checks++; if (bus.stall_d !== 1'b1) begin n_fail++; $display("FAIL stall_run cyc %0d got %b want 1", i + 1, bus.stall_d); end
      step();
      bus.start = 1'b0; bus.op = 3'd0;
    end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL stall_done got %b want 0", bus.busy); end
    n_checks++; if (bus.stall_d !== 1'b0) begin n_fail++; $display("FAIL stall_fall got %b want 0", bus.stall_d); end
    n_checks++; if (bus.lo !== 32'd14) begin n_fail++; $display("FAIL ignstart_lo got %h want 0000000e", bus.lo); end
    n_checks++; if (bus.hi !== 32'd2) begin n_fail++; $display("FAIL ignstart_hi got %h want 00000002", bus.hi); end
    step();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ignstart_rebusy got %b want 0", bus.busy); end
    bus.d_mdu_use = 1'b0;
  endtask

  task automatic test_madd();
    issue(3'd5, 32'd0, 32'd0, 1'b0);
    issue(3'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
    issue(3'd7, 32'd1, 32'd1, 1'b0);
`ifdef MDU_MADD_EN
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL madd_busy cyc %0d got %b want 1", i + 1, bus.busy); end
      step();
    end
    n_checks++; if (bus.hi !== 32'd1) begin n_fail++; $display("FAIL madd_hi got %h want 00000001", bus.hi); end
    n_checks++; if (bus.lo !== 32'd0) begin n_fail++; $display("FAIL madd_lo got %h want 0", bus.lo); end
`else
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL op7_busy got %b want 0", bus.busy); end
    repeat (6) step();
    n_checks++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL op7_hi got %h want 0", bus.hi); end
    n_checks++; if (bus.lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL op7_lo got %h want ffffffff", bus.lo); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.req = 1'b0; bus.start = 1'b0; bus.op = 3'd0;
    bus.a = 32'd0; bus.b = 32'd0; bus.d_mdu_use = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_abort();
    test_req_commit();
    test_stall();
    test_madd();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle controller for the Execute-stage multiply/divide resource.
- Accepts one MDU operation per start pulse from E-stage decode and holds busy for a fixed latency.
- Commits results to architectural HI/LO and raises a D-stage stall while any MDU-using instruction must wait.
- Cancels in-flight work on exception/interrupt request (req) so HI/LO stay precise.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd when enabled); legal range 1..31
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..31

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req  input  1  exception/interrupt flush; cancels pending op, blocks start
- start  input  1  one-cycle issue pulse from E-stage decode
- op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd (optional)
- a  input  32  forwarded rs value
- b  input  32  forwarded rt value
- d_mdu_use  input  1  D-stage instruction uses MDU (mult/div/mf*/mt*)
- busy  output  1  multi-cycle op in progress
- stall_d  output  1  combinational: d_mdu_use && (start || busy)
- hi  output  32  architectural HI
- lo  output  32  architectural LO

Behaviour:
- Reset: state IDLE; busy=0; hi=0; lo=0; counter=0; pending registers=0. Reset overrides req and start.
- FSM has two states, IDLE and RUN.
- IDLE + start + !req:
  - op 1–4 (and 7 if enabled): compute 64-bit result into pending_hi/pending_lo at this edge; load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - op 5: hi<=a at the next edge; no busy.
  - op 6: lo<=a at the next edge; no busy.
  - op 0 (or 7 when disabled): no effect.
- RUN:
  - Counter decrements each cycle; busy=1 for exactly N cycles (cycles t+1..t+N after start sampled at edge t).
  - On the edge where counter==1: hi<=pending_hi, lo<=pending_lo, go to IDLE. busy falls in the same cycle hi/lo become visible.
- start while RUN: ignored (stall_d prevents it architecturally); pending and counter unchanged.
- req in IDLE: start in the same cycle is ignored; mthi/mtlo are not committed.
- req in RUN: abort to IDLE, busy=0 next cycle, pending discarded, hi/lo unchanged.
- req on the commit edge (counter==1): abort takes priority; no commit.
- Arithmetic:
  - mult: signed 32x32 -> {hi,lo}.
  - multu: unsigned 32x32 -> {hi,lo}.
  - div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - Divide by zero (div/divu): lo=32'hFFFF_FFFF, hi=a.
  - Signed overflow, div 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0.
- Operands are sampled only at the start edge; later changes on a/b have no effect.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: op 7 = madd. pending {hi,lo} = current {hi,lo} + signed(a)*signed(b), modulo 2^64. The accumulator base is the hi/lo value at the start edge. Latency is MULT_CYCLES; cancellation rules as for mult.
- Undefined: op 7 is a no-op; no adder hardware.

Test Plan:
- mult a=0xFFFF_FFFE (-2), b=3 at edge t -> busy high t+1..t+5, then hi=0xFFFF_FFFF, lo=0xFFFF_FFFA; multu with the same operands -> hi=0x0000_0002, lo=0xFFFF_FFFA.
- div a=0xFFFF_FFF9 (-7), b=2 -> busy 10 cycles, then lo=0xFFFF_FFFD, hi=0xFFFF_FFFF; divu a=7, b=0 -> lo=0xFFFF_FFFF, hi=7.
- Start div, assert req at busy cycle 4 -> busy=0 next cycle; hi/lo keep prior values (preload via mthi 0x1234, mtlo 0x5678).
- req on the cycle counter==1 -> no commit; start+req in the same cycle -> no busy, no hi/lo change.
- d_mdu_use=1 with start=1 -> stall_d=1 that cycle and through all busy cycles; stall_d=0 the cycle busy falls; start while busy -> ignored.
- MDU_MADD_EN: hi=0, lo=0xFFFF_FFFF, madd a=1, b=1 -> hi=1, lo=0 after 5 cycles; without the macro -> op 7 leaves busy=0 and hi/lo unchanged.
